uart_tx_fsm: RTL and testbench

//  UART transmit framer: the stage that drives the baud generator and consumes its tick.

---
 rtl/uart_tx_fsm.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_fsm.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm
// UART transmit framer. Takes a parallel word through a start/busy handshake
// and serialises it as: start bit, data LSB-first, optional parity bit, then
// one or two stop bits. The framer owns the baud generator enable (baud_en)
// for the whole frame and advances exactly one bit per baud_tick.
//
// Handshake: a word is accepted on any rising clk edge where tx_start=1 and
// tx_busy=0. From that edge until tx_done, tx_start and tx_data are ignored
// and the latched word is never modified. tx_done is a one-cycle pulse on the
// cycle after the last stop bit's tick; tx_busy is already low in that cycle,
// so a request held high there starts the next frame with no idle bit on tx.
//
// Every output comes straight from a flop, so tx is glitch-free at the pin.

module uart_tx_fsm #(
    parameter int DATA_BITS = 8,  // 5..9
    parameter int PARITY    = 0,  // 0 = none, 1 = odd, 2 = even
    parameter int STOP_BITS = 1   // 1 or 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 baud_tick,
    output logic                 baud_en,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    // Frame phases. Any other encoding is treated as IDLE.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Index of the last data bit and of the last stop bit.
    localparam logic [3:0] LAST_BIT   = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP  = 1'(STOP_BITS - 1);
    localparam logic       HAS_PARITY = (PARITY != 0);
    localparam logic       ODD_PARITY = (PARITY == 1);

    // Registered state.
    logic [2:0]           state_q,    state_d;
    logic [DATA_BITS-1:0] data_q,     data_d;     // word as accepted, for parity
    logic [DATA_BITS-1:0] shift_q,    shift_d;    // bit 0 is the next data bit out
    logic [3:0]           bit_cnt_q,  bit_cnt_d;  // data bit currently on tx
    logic                 stop_cnt_q, stop_cnt_d; // stop bit currently on tx
    logic                 tx_q,       tx_d;
    logic                 baud_en_q,  baud_en_d;
    logic                 busy_q,     busy_d;
    logic                 done_q,     done_d;

    logic                 parity_bit;

    // Parity bit for the latched word: even parity sends the XOR of the data
    // so the total count of ones is even; odd parity sends its complement.
    always_comb begin
        parity_bit = ^data_q;
        if (ODD_PARITY) begin
            parity_bit = ~(^data_q);
        end
    end

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        baud_en_d  = baud_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Line idles high and the generator is stopped; ticks are ignored.
                tx_d      = 1'b1;
                baud_en_d = 1'b0;
                busy_d    = 1'b0;
                if (tx_start && !busy_q) begin
                    data_d     = tx_data;
                    shift_d    = tx_data;
                    bit_cnt_d  = 4'd0;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b0;  // start bit begins on the accept edge
                    baud_en_d  = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_START;
                end
            end

            ST_START: begin
                if (baud_tick) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = 4'd0;
                    state_d   = ST_DATA;
                end
            end

            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (HAS_PARITY) begin
                            tx_d    = parity_bit;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = ST_STOP;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end

            ST_PARITY: begin
                if (baud_tick) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = ST_STOP;
                end
            end

            ST_STOP: begin
                tx_d = 1'b1;
                if (baud_tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        // Frame complete: release the generator and the handshake.
                        baud_en_d = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                // Unreachable encodings recover to a quiet idle line.
                tx_d       = 1'b1;
                baud_en_d  = 1'b0;
                busy_d     = 1'b0;
                bit_cnt_d  = 4'd0;
                stop_cnt_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any frame and idles the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= 4'd0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            baud_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            baud_en_q  <= baud_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx      = tx_q;
    assign baud_en = baud_en_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Testbench for uart_tx_fsm. Four instances cover 8N1, 8O1, 8E1 and 8N2.
// Inputs are driven and outputs sampled on the falling clock edge.
// A bit period is 16 clocks: tx is sampled mid-period, then baud_tick pulses.

module tb_uart_tx_fsm;

    logic       clk;
    logic       rst;
    logic [3:0] start;
    logic [7:0] tx_data;
    logic       baud_tick;

    logic [3:0] tx_w;
    logic [3:0] busy_w;
    logic [3:0] en_w;
    logic [3:0] done_w;

    int         sel;
    logic       obs_tx;
    logic       obs_busy;
    logic       obs_en;
    logic       obs_done;

    int         checks   = 0;
    int         failures = 0;
    int         done_cnt0 = 0;

    uart_tx_fsm #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .tx_start(start[0]), .tx_data(tx_data),
        .baud_tick(baud_tick), .baud_en(en_w[0]), .tx(tx_w[0]),
        .tx_busy(busy_w[0]), .tx_done(done_w[0])
    );

    uart_tx_fsm #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .tx_start(start[1]), .tx_data(tx_data),
        .baud_tick(baud_tick), .baud_en(en_w[1]), .tx(tx_w[1]),
        .tx_busy(busy_w[1]), .tx_done(done_w[1])
    );

    uart_tx_fsm #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .tx_start(start[2]), .tx_data(tx_data),
        .baud_tick(baud_tick), .baud_en(en_w[2]), .tx(tx_w[2]),
        .tx_busy(busy_w[2]), .tx_done(done_w[2])
    );

    uart_tx_fsm #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst(rst), .tx_start(start[3]), .tx_data(tx_data),
        .baud_tick(baud_tick), .baud_en(en_w[3]), .tx(tx_w[3]),
        .tx_busy(busy_w[3]), .tx_done(done_w[3])
    );

    assign obs_tx   = tx_w[sel];
    assign obs_busy = busy_w[sel];
    assign obs_en   = en_w[sel];
    assign obs_done = done_w[sel];

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count tx_done pulses of the 8N1 instance.
    always @(negedge clk) begin
        if (done_w[0] === 1'b1) done_cnt0 = done_cnt0 + 1;
    end

    // Driver: present a word on one channel for a single accept edge.
    task automatic start_frame(input int ch, input logic [7:0] data);
        @(negedge clk);
        tx_data   = data;
        start[ch] = 1'b1;
        @(negedge clk);
        start[ch] = 1'b0;
    endtask

    // Driver: one 16-clock bit period, returning mid-period observations and
    // tx_done as seen right after the closing tick.
    task automatic bit_period(output logic mid_tx, output logic mid_busy,
                              output logic done_after);
        repeat (8) @(negedge clk);
        mid_tx   = obs_tx;
        mid_busy = obs_busy;
        repeat (7) @(negedge clk);
        baud_tick = 1'b1;
        @(negedge clk);
        baud_tick  = 1'b0;
        done_after = obs_done;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 4'b0000;
        tx_data   = 8'h00;
        baud_tick = 1'b0;
        repeat (3) @(negedge clk);
        for (int ch = 0; ch < 4; ch++) begin
            sel = ch;
            #1;
            checks++;
            if ({obs_tx, obs_busy, obs_en, obs_done} !== 4'b1000) begin
                failures++;
                $display("FAIL reset_outputs ch%0d: got tx/busy/en/done=%b required 1000",
                         ch, {obs_tx, obs_busy, obs_en, obs_done});
            end
        end
        rst = 1'b0;
        sel = 0;
        // Ticks in IDLE must not start anything.
        baud_tick = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0;
        @(negedge clk);
        checks++;
        if ({obs_tx, obs_busy, obs_en} !== 3'b100) begin
            failures++;
            $display("FAIL idle_ignores_tick: got tx/busy/en=%b required 100",
                     {obs_tx, obs_busy, obs_en});
        end
    endtask

    task automatic test_8n1();
        logic [11:0] fr;
        logic m, b, d;
        int snap;
        sel  = 0;
        fr   = 12'b00_1_10100101_0;  // stop, 0xA5, start (bit 0 first)
        #1 snap = done_cnt0;
        start_frame(0, 8'hA5);
        checks++;
        if ({obs_tx, obs_busy, obs_en} !== 3'b011) begin
            failures++;
            $display("FAIL 8n1_accept: got tx/busy/en=%b required 011",
                     {obs_tx, obs_busy, obs_en});
        end
        for (int i = 0; i < 10; i++) begin
            bit_period(m, b, d);
            checks++;
            if (m !== fr[i]) begin
                failures++;
                $display("FAIL 8n1_bit%0d: got tx=%b required %b", i, m, fr[i]);
            end
            checks++;
            if (d !== (i == 9)) begin
                failures++;
                $display("FAIL 8n1_done_tick%0d: got tx_done=%b required %b", i, d, (i == 9));
            end
        end
        checks++;
        if ({obs_tx, obs_busy, obs_en} !== 3'b100) begin
            failures++;
            $display("FAIL 8n1_end: got tx/busy/en=%b required 100",
                     {obs_tx, obs_busy, obs_en});
        end
        @(negedge clk);
        #1;
        checks++;
        if (obs_done !== 1'b0 || done_cnt0 - snap !== 1) begin
            failures++;
            $display("FAIL 8n1_done_pulse: got done=%b pulses=%0d required 0 and 1",
                     obs_done, done_cnt0 - snap);
        end
    endtask

    task automatic test_parity();
        logic [11:0] fr;
        logic m, b, d;
        for (int ch = 1; ch <= 2; ch++) begin
            sel = ch;
            // 0x07 has three ones: odd parity sends 0, even parity sends 1.
            fr  = (ch == 1) ? 12'b0_1_0_00000111_0 : 12'b0_1_1_00000111_0;
            start_frame(ch, 8'h07);
            for (int i = 0; i < 11; i++) begin
                bit_period(m, b, d);
                checks++;
                if (m !== fr[i]) begin
                    failures++;
                    $display("FAIL parity_ch%0d_bit%0d: got tx=%b required %b", ch, i, m, fr[i]);
                end
                if (i >= 9) begin
                    checks++;
                    if (d !== (i == 10)) begin
                        failures++;
                        $display("FAIL parity_ch%0d_done%0d: got tx_done=%b required %b",
                                 ch, i, d, (i == 10));
                    end
                end
            end
        end
        sel = 0;
    endtask

    task automatic test_two_stop();
        logic [11:0] fr;
        logic m, b, d;
        sel = 3;
        fr  = 12'b0_11_11111111_0;
        start_frame(3, 8'hFF);
        for (int i = 0; i < 11; i++) begin
            bit_period(m, b, d);
            checks++;
            if (m !== fr[i] || b !== 1'b1) begin
                failures++;
                $display("FAIL 8n2_bit%0d: got tx=%b busy=%b required tx=%b busy=1",
                         i, m, b, fr[i]);
            end
            if (i >= 9) begin
                checks++;
                if (d !== (i == 10)) begin
                    failures++;
                    $display("FAIL 8n2_done%0d: got tx_done=%b required %b", i, d, (i == 10));
                end
            end
        end
        checks++;
        if (obs_busy !== 1'b0) begin
            failures++;
            $display("FAIL 8n2_busy_end: got busy=%b required 0", obs_busy);
        end
        sel = 0;
    endtask

    task automatic test_ignore_midframe();
        logic [11:0] fr;
        logic m, b, d;
        int snap;
        sel = 0;
        fr  = 12'b00_1_10100101_0;
        #1 snap = done_cnt0;
        start_frame(0, 8'hA5);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                // Competing request with different data during data bit 3.
                tx_data  = 8'h3C;
                start[0] = 1'b1;
                @(negedge clk);
                start[0] = 1'b0;
            end
            bit_period(m, b, d);
            checks++;
            if (m !== fr[i]) begin
                failures++;
                $display("FAIL midreq_bit%0d: got tx=%b required %b", i, m, fr[i]);
            end
        end
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (obs_busy !== 1'b0 || obs_tx !== 1'b1 || done_cnt0 - snap !== 1) begin
            failures++;
            $display("FAIL midreq_dropped: got busy=%b tx=%b pulses=%0d required 0 1 1",
                     obs_busy, obs_tx, done_cnt0 - snap);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] fr1;
        logic [11:0] fr2;
        logic m, b, d;
        int snap;
        sel = 0;
        fr1 = 12'b00_1_01010101_0;
        fr2 = 12'b00_1_10101010_0;
        #1 snap = done_cnt0;
        @(negedge clk);
        tx_data  = 8'h55;
        start[0] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            bit_period(m, b, d);
            checks++;
            if (m !== fr1[i]) begin
                failures++;
                $display("FAIL b2b_f1_bit%0d: got tx=%b required %b", i, m, fr1[i]);
            end
        end
        checks++;
        if ({obs_done, obs_en, obs_tx} !== 3'b101) begin
            failures++;
            $display("FAIL b2b_done_cycle: got done/en/tx=%b required 101",
                     {obs_done, obs_en, obs_tx});
        end
        tx_data = 8'hAA;
        @(negedge clk);
        start[0] = 1'b0;
        checks++;
        if ({obs_tx, obs_busy, obs_en, obs_done} !== 4'b0110) begin
            failures++;
            $display("FAIL b2b_restart: got tx/busy/en/done=%b required 0110",
                     {obs_tx, obs_busy, obs_en, obs_done});
        end
        for (int i = 0; i < 10; i++) begin
            bit_period(m, b, d);
            checks++;
            if (m !== fr2[i]) begin
                failures++;
                $display("FAIL b2b_f2_bit%0d: got tx=%b required %b", i, m, fr2[i]);
            end
        end
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (obs_busy !== 1'b0 || done_cnt0 - snap !== 2) begin
            failures++;
            $display("FAIL b2b_end: got busy=%b pulses=%0d required 0 and 2",
                     obs_busy, done_cnt0 - snap);
        end
    endtask

    task automatic test_reset_midframe();
        logic [11:0] fr;
        logic m, b, d;
        int snap;
        sel = 0;
        fr  = 12'b00_1_10100101_0;
        #1 snap = done_cnt0;
        start_frame(0, 8'hA5);
        for (int i = 0; i < 4; i++) begin
            bit_period(m, b, d);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (obs_tx !== fr[4] || obs_busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre: got tx=%b busy=%b required %b 1", obs_tx, obs_busy, fr[4]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({obs_tx, obs_busy, obs_en, obs_done} !== 4'b1000) begin
            failures++;
            $display("FAIL rstmid_async: got tx/busy/en/done=%b required 1000",
                     {obs_tx, obs_busy, obs_en, obs_done});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (obs_tx !== 1'b1 || obs_busy !== 1'b0 || done_cnt0 - snap !== 0) begin
            failures++;
            $display("FAIL rstmid_after: got tx=%b busy=%b pulses=%0d required 1 0 0",
                     obs_tx, obs_busy, done_cnt0 - snap);
        end
        fr = 12'b00_1_00111100_0;
        start_frame(0, 8'h3C);
        for (int i = 0; i < 10; i++) begin
            bit_period(m, b, d);
            checks++;
            if (m !== fr[i]) begin
                failures++;
                $display("FAIL rstmid_next_bit%0d: got tx=%b required %b", i, m, fr[i]);
            end
        end
        #1;
        checks++;
        if (done_cnt0 - snap !== 1) begin
            failures++;
            $display("FAIL rstmid_next_done: got pulses=%0d required 1", done_cnt0 - snap);
        end
    endtask

    initial begin
        sel = 0;
        test_reset();
        test_8n1();
        test_parity();
        test_two_stop();
        test_ignore_midframe();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
